// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction-fetch prefetch unit: default address
// and instruction widths, the reset fetch address, the fetch-entry layout
// stored in the instruction queue, and the prefetch sequencer states.
// -----------------------------------------------------------------------------
package ifu_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  // Every fetch is one fixed-size instruction word.
  localparam int unsigned INST_BYTES = 4;

  // One instruction-queue entry: where it came from, what it is, and whether
  // the memory reported an access fault for it.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
    logic                err;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Occupancy counters need one bit more than an index so that "full"
  // (== depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered storage array and a combinational view
// of the head slot. Pointers carry one wrap bit so full and empty are told
// apart without a separate counter.
//
// Ports
//   clk      clock
//   rst_n    synchronous active-low reset (pointers only)
//   flush_i  discard all entries; wins over push and pop in the same cycle
//   push_i   write wdata_i at the tail (ignored when full unless popping)
//   wdata_i  entry to write
//   pop_i    drop the head entry (ignored when empty)
//   rdata_o  head entry contents (don't-care while empty)
//   empty_o  no entries held
//   count_o  number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full queue is fine when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_push = push_i & (~full | pop_i) & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers define which
  // slots are meaningful, and a reset on the array would just cost a wide mux.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
// Sequential instruction prefetcher. Issues 4-byte aligned fetch requests as
// long as queue occupancy plus outstanding requests leaves room, tags in-order
// responses with their PC, and queues them for decode. A redirect flushes the
// queue, restarts fetching at the new target and arranges for every response
// still outstanding from the old path to be discarded on arrival.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset           synchronous active-low reset
//   req_valid       fetch request valid (from registered state only)
//   req_ready       memory accepts the request
//   req_addr        fetch address
//   rsp_valid       in-order response valid, never back-pressured
//   rsp_data        fetched instruction
//   rsp_err         access fault for this response
//   redirect_valid  one-cycle branch/jump redirect
//   redirect_pc     redirect target (low two bits ignored)
//   out_valid       head queue entry valid
//   out_ready       decode consumes the head entry
//   out_pc          PC of the head entry
//   out_inst        instruction of the head entry
//   out_err         fault flag of the head entry
// -----------------------------------------------------------------------------
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  input  logic            rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            out_err
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Same field order as fetch_entry_t, sized to this instance's widths.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   q_count;
  logic            q_empty;
  entry_t          q_wdata, q_rdata;

  logic            credit_ok;
  logic            fire, accept, enq, pop;
  logic [XLEN-1:0] redir_pc_al;

  // Outstanding requests reserve a queue slot, so a response always has
  // somewhere to land even while decode is stalled.
  assign credit_ok = ({1'b0, q_count} + {1'b0, inflight_q}) < DEPTH_C;

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  req_valid = credit_ok;
      default: state_d = ST_BOOT;
    endcase
  end

  assign fire        = req_valid & req_ready;
  assign accept      = rsp_valid & (inflight_q != '0);
  // A response accepted in a redirect cycle belongs to the abandoned path.
  assign enq         = accept & (drop_q == '0) & ~redirect_valid;
  assign pop         = out_valid & out_ready & ~redirect_valid;
  assign redir_pc_al = redirect_pc & ~XLEN'(3);

  always_comb begin
    inflight_d = inflight_q + CW'(fire) - CW'(accept);

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = redir_pc_al;
      rsp_pc_d   = redir_pc_al;
      // Everything still owed by memory after this edge, including a request
      // that fired this very cycle, is from the old path.
      drop_d     = inflight_d;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (enq)  rsp_pc_d   = rsp_pc_q + XLEN'(INST_BYTES);
      if (accept && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign q_wdata = '{pc: rsp_pc_q, inst: rsp_data, err: rsp_err};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (enq),
    .wdata_i (q_wdata),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign req_addr  = fetch_pc_q;
  assign out_valid = ~q_empty;
  assign out_pc    = q_rdata.pc;
  assign out_inst  = q_rdata.inst;
  assign out_err   = q_rdata.err;

endmodule
